// File: rtl/register_bank.sv
// Addressed register file with CLR/LOAD/INC/DEC op port, two async read ports and a CARRY pulse.
// Optional build macro REGBANK_SATURATE_EN: INC/DEC saturate at the range ends instead of wrapping.
module register_bank_cell #(
    parameter int WIDTH = 19
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge CLK) begin
        if (!RST_N)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module register_bank #(
    parameter int WIDTH  = 19,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [WIDTH-1:0]  inpData,
    input  logic              LOAD,
    input  logic              INC,
    input  logic              DEC,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] RADDR_A,
    input  logic [ADDR_W-1:0] RADDR_B,
    output logic [WIDTH-1:0]  opDataA,
    output logic [WIDTH-1:0]  opDataB,
    output logic              ZERO_A,
    output logic              CARRY
);
    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            sel;
    logic [WIDTH-1:0]            cur, wdata;
    logic                        we, carry_d, at_max, at_zero;

    // Address decode doubles as the range check: no select bit means ADDR >= DEPTH.
    always_comb begin
        sel = '0;
        cur = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ADDR == ADDR_W'(i)) begin
                sel[i] = 1'b1;
                cur    = regs[i];
            end
        end
    end

    assign at_max  = &cur;
    assign at_zero = ~|cur;

    always_comb begin
        we      = 1'b0;
        wdata   = cur;
        carry_d = 1'b0;
        if (|sel) begin
            if (CLR) begin
                we    = 1'b1;
                wdata = '0;
            end else if (LOAD) begin
                we    = 1'b1;
                wdata = inpData;
            end else if (INC) begin
                we      = 1'b1;
                carry_d = at_max;
`ifdef REGBANK_SATURATE_EN
                wdata   = at_max ? cur : cur + WIDTH'(1);
`else
                wdata   = cur + WIDTH'(1);
`endif
            end else if (DEC) begin
                we      = 1'b1;
                carry_d = at_zero;
`ifdef REGBANK_SATURATE_EN
                wdata   = at_zero ? cur : cur - WIDTH'(1);
`else
                wdata   = cur - WIDTH'(1);
`endif
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        register_bank_cell #(.WIDTH(WIDTH)) u_cell (
            .CLK  (CLK),
            .RST_N(RST_N),
            .we   (we & sel[g]),
            .d    (wdata),
            .q    (regs[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) CARRY <= 1'b0;
        else        CARRY <= carry_d;
    end

    // Reads are unbypassed: a same-cycle write shows up only after the edge.
    always_comb begin
        opDataA = '0;
        opDataB = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (RADDR_A == ADDR_W'(i)) opDataA = regs[i];
            if (RADDR_B == ADDR_W'(i)) opDataB = regs[i];
        end
    end

    assign ZERO_A = (opDataA == '0);
endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: a DEPTH=8 and a DEPTH=6 instance share one stimulus stream
// and are checked every cycle against an integer-level model, plus hand-computed literal points.
module tb_register_bank;
    localparam int MAX = 524287;
`ifdef REGBANK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  addr, raddr_a, raddr_b;
    logic [18:0] data;
    logic        load, inc, dec, clr;
    logic [18:0] a8, b8, a6, b6;
    logic        z8, c8, z6, c6;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    register_bank #(.WIDTH(19), .DEPTH(8), .ADDR_W(3)) dut8 (
        .CLK(clk), .RST_N(rst_n), .ADDR(addr), .inpData(data),
        .LOAD(load), .INC(inc), .DEC(dec), .CLR(clr),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b),
        .opDataA(a8), .opDataB(b8), .ZERO_A(z8), .CARRY(c8)
    );

    register_bank #(.WIDTH(19), .DEPTH(6), .ADDR_W(3)) dut6 (
        .CLK(clk), .RST_N(rst_n), .ADDR(addr), .inpData(data),
        .LOAD(load), .INC(inc), .DEC(dec), .CLR(clr),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b),
        .opDataA(a6), .opDataB(b6), .ZERO_A(z6), .CARRY(c6)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: plain integer registers per instance, updated by the op rules on each edge.
    int m[2][8];
    bit mc[2];
    bit armed = 1'b0;
    int dep[2] = '{8, 6};

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 8; i++) m[k][i] = 0;
                mc[k] = 1'b0;
            end
            armed = 1'b1;
        end else if (armed) begin
            for (int k = 0; k < 2; k++) begin
                bit c;
                int v;
                c = 1'b0;
                if (int'(addr) < dep[k]) begin
                    v = m[k][addr];
                    if (clr) v = 0;
                    else if (load) v = int'(data);
                    else if (inc) begin
                        if (v == MAX) begin c = 1'b1; v = SAT ? MAX : 0; end
                        else v = v + 1;
                    end else if (dec) begin
                        if (v == 0) begin c = 1'b1; v = SAT ? 0 : MAX; end
                        else v = v - 1;
                    end
                    m[k][addr] = v;
                end
                mc[k] = c;
            end
        end
    end

    function automatic int exp_rd(input int k, input logic [2:0] ra);
        return (int'(ra) < dep[k]) ? m[k][ra] : 0;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            chk("cmp_a8", int'(a8), exp_rd(0, raddr_a));
            chk("cmp_b8", int'(b8), exp_rd(0, raddr_b));
            chk("cmp_z8", int'(z8), int'(exp_rd(0, raddr_a) == 0));
            chk("cmp_c8", int'(c8), int'(mc[0]));
            chk("cmp_a6", int'(a6), exp_rd(1, raddr_a));
            chk("cmp_b6", int'(b6), exp_rd(1, raddr_b));
            chk("cmp_z6", int'(z6), int'(exp_rd(1, raddr_a) == 0));
            chk("cmp_c6", int'(c6), int'(mc[1]));
        end
    end

    task automatic op(input logic [2:0] a, input int d, input logic l, input logic i,
                      input logic dc, input logic c);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        addr  = a;
        data  = 19'(d);
        load  = l;
        inc   = i;
        dec   = dc;
        clr   = c;
    endtask

    task automatic nop();
        op(3'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rst_op(input logic [2:0] a, input logic l, input logic i);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        addr  = a;
        data  = 19'd77;
        load  = l;
        inc   = i;
        dec   = 1'b0;
        clr   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; data = '0;
        load = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
        raddr_a = '0; raddr_b = '0;
        repeat (2) @(posedge clk);

        // Reset with LOAD asserted wipes preloaded values
        op(3'd0, 5, 1, 0, 0, 0);
        op(3'd6, 9, 1, 0, 0, 0);
        rst_op(3'd0, 1'b1, 1'b0);
        rst_op(3'd0, 1'b1, 1'b0);
        nop(); raddr_a = 3'd0; raddr_b = 3'd6; #1;
        chk("rst_a", int'(a8), 0);
        chk("rst_b", int'(b8), 0);
        chk("rst_zero", int'(z8), 1);
        chk("rst_carry", int'(c8), 0);

        // Load / read / inc / dec / clr
        op(3'd3, 2349, 1, 0, 0, 0);
        op(3'd5, 100, 1, 0, 0, 0);
        nop(); raddr_a = 3'd3; raddr_b = 3'd5; #1;
        chk("load_a", int'(a8), 2349);
        chk("load_b", int'(b8), 100);
        op(3'd3, 0, 0, 1, 0, 0);
        op(3'd5, 0, 0, 0, 1, 0);
        nop(); #1;
        chk("inc_a", int'(a8), 2350);
        chk("dec_b", int'(b8), 99);
        op(3'd3, 0, 0, 0, 0, 1);
        nop(); #1;
        chk("clr_a", int'(a8), 0);
        chk("clr_zero", int'(z8), 1);

        // Priority
        op(3'd2, 7, 1, 0, 0, 0);
        op(3'd2, 123, 1, 1, 0, 1);
        nop(); raddr_a = 3'd2; #1;
        chk("prio_clr", int'(a8), 0);
        op(3'd2, 40, 1, 1, 0, 0);
        nop(); #1;
        chk("prio_load", int'(a8), 40);
        op(3'd2, 0, 0, 1, 1, 0);
        nop(); #1;
        chk("prio_inc", int'(a8), 41);

        // Wrap / saturate at both ends
        op(3'd1, MAX, 1, 0, 0, 0);
        op(3'd1, 0, 0, 1, 0, 0);
        nop(); raddr_a = 3'd1; #1;
        chk("inc_top", int'(a8), SAT ? MAX : 0);
        chk("inc_carry", int'(c8), 1);
        nop(); #1;
        chk("carry_pulse", int'(c8), 0);
        op(3'd1, 0, 0, 0, 0, 1);
        op(3'd1, 0, 0, 0, 1, 0);
        nop(); #1;
        chk("dec_bottom", int'(a8), SAT ? 0 : MAX);
        chk("dec_borrow", int'(c8), 1);

        // Read during write: old value before the edge, new one after
        op(3'd4, 10, 1, 0, 0, 0);
        nop(); raddr_a = 3'd4; raddr_b = 3'd2;
        op(3'd4, 55, 1, 0, 0, 0); #1;
        chk("rdw_old", int'(a8), 10);
        nop(); #1;
        chk("rdw_new", int'(a8), 55);
        chk("rdw_other", int'(b8), 41);

        // Out of range on the DEPTH=6 instance
        op(3'd7, 123, 1, 0, 0, 0);
        op(3'd6, 0, 0, 0, 1, 0);
        nop(); raddr_a = 3'd7; raddr_b = 3'd7; #1;
        chk("oor_b6", int'(b6), 0);
        chk("oor_z6", int'(z6), 1);
        chk("oor_c6", int'(c6), 0);
        chk("inrange_b8", int'(b8), 123);

        // Reset wins over a wrapping INC in the same cycle
        op(3'd1, MAX, 1, 0, 0, 0);
        rst_op(3'd1, 1'b0, 1'b1);
        nop(); raddr_a = 3'd1; raddr_b = 3'd4; #1;
        chk("rst_inc_a", int'(a8), 0);
        chk("rst_inc_carry", int'(c8), 0);
        chk("rst_inc_b", int'(b8), 0);

        repeat (3) nop();
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
